// File: rtl/alu_result_checker.sv
// Receiving end of the ALU stimulus path: recomputes each (op, a, b) result,
// compares it with the DUT result r and keeps per-session pass/fail statistics.
module alu_result_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid,
  input  logic             last,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] r,
  output logic             ready,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err,
  output logic             done,
  output logic             pass,
  output logic [1:0]       state_dbg
);

  // Handshake: a vector transfers on any rising edge where valid && ready;
  // ready is high only in RUN and there is no backpressure inside RUN.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic             accept;
  logic             clear;
  logic             stage1_v;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic [WIDTH-1:0] exp_res;
  logic             bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    clear     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          clear     = 1'b1;
        end
      end
      S_RUN: begin
        if (valid) begin
          accept = 1'b1;
          if (last) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: state_nxt = S_DONE;
      S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          clear     = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage 1: capture the accepted vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_v <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
    end else begin
      stage1_v <= accept;
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
        r_q  <= r;
      end
    end
  end

  always_comb begin
    exp_res = '0;
    case (op_q)
      3'b000: exp_res = a_q & b_q;
      3'b001: exp_res = a_q | b_q;
      3'b010: exp_res = a_q + b_q;
      3'b011: exp_res = a_q ^ b_q;
      3'b100: exp_res = ~(a_q | b_q);
      3'b101: exp_res = a_q - b_q;
      3'b110: exp_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      3'b111: exp_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      default: exp_res = '0;
    endcase
  end

  assign bad = stage1_v && (exp_res != r_q);

  // Stage 2: statistics. Counters stick at all-ones; first_err latches once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count <= '0;
      err_count <= '0;
      first_err <= '1;
      mismatch  <= 1'b0;
    end else if (clear) begin
      vec_count <= '0;
      err_count <= '0;
      first_err <= '1;
      mismatch  <= 1'b0;
    end else begin
      mismatch <= bad;
      if (stage1_v && (vec_count != '1)) vec_count <= vec_count + CNT_ONE;
      if (bad) begin
        if (err_count != '1) err_count <= err_count + CNT_ONE;
        if (first_err == '1) first_err <= vec_count;
      end
    end
  end

  assign ready     = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign pass      = done && (err_count == '0);
  assign state_dbg = state;

endmodule
